// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity codes and the parity helper.
// Used by both the transmitter and the receiver.
package uart_pkg;

    localparam int MAX_DATA_BITS = 9;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } uart_state_t;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;
    localparam logic [1:0] PAR_MARK = 2'd3;

    // Callers zero-extend narrower words; the extra zeros do not change the XOR.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] word,
                                        input logic [1:0]               ptype);
        logic p;
        case (ptype)
            PAR_ODD:  p = ~^word;
            PAR_EVEN: p = ^word;
            PAR_MARK: p = 1'b1;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Small first-word-fall-through FIFO; head word is visible on dout whenever not empty.
// Pushes while full are dropped, pops while empty are ignored.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    // Full/empty come from the registered count, so a pop never unblocks a same-cycle push.
    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr_reg];
    assign count   = count_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed frame FSM with configurable width, parity and stop bits.
// The line register follows the FSM state one cycle later, so every level lasts CLKS_PER_BIT cycles.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 434,
    parameter int DATA_BITS     = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int CLK_CTR_WIDTH = $clog2(CLKS_PER_BIT)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [1:0]                    parity_type,
    input  logic                          two_stop,
    output logic                          serial_out,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CLK_CTR_WIDTH-1:0] BAUD_LAST = CLK_CTR_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]         BIT_LAST  = BIT_W'(DATA_BITS - 1);

    uart_state_t               state_reg;
    uart_state_t               state_next;
    logic [CLK_CTR_WIDTH-1:0]  baud_reg;
    logic [BIT_W-1:0]          bit_idx_reg;
    logic                      stop_idx_reg;
    logic [DATA_BITS-1:0]      shift_reg;
    logic                      parity_reg;
    logic [1:0]                par_cfg_reg;
    logic                      two_stop_cfg_reg;
    logic                      serial_reg;
    logic [DATA_BITS-1:0]      fifo_dout;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_pop;
    logic                      bit_end;
    logic [MAX_DATA_BITS-1:0]  word_ext;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .pop   (fifo_pop),
        .din   (in_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign in_ready   = !fifo_full;
    assign busy       = (state_reg != IDLE);
    assign serial_out = serial_reg;
    assign bit_end    = (state_reg != IDLE) && (baud_reg == BAUD_LAST);

    always_comb begin
        word_ext = '0;
        word_ext[DATA_BITS-1:0] = fifo_dout;
    end

    always_comb begin
        state_next = state_reg;
        fifo_pop   = 1'b0;
        tx_done    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                if (bit_end && (bit_idx_reg == BIT_LAST)) begin
                    state_next = (par_cfg_reg != PAR_NONE) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) state_next = STOP;
            end
            STOP: begin
                if (bit_end && (stop_idx_reg == two_stop_cfg_reg)) begin
                    tx_done    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_reg         <= '0;
            bit_idx_reg      <= '0;
            stop_idx_reg     <= 1'b0;
            shift_reg        <= '0;
            parity_reg       <= 1'b0;
            par_cfg_reg      <= PAR_NONE;
            two_stop_cfg_reg <= 1'b0;
            serial_reg       <= 1'b1;
        end else begin
            if (state_reg == IDLE || bit_end) begin
                baud_reg <= '0;
            end else begin
                baud_reg <= baud_reg + 1'b1;
            end

            // Config and parity are frozen at pop so host changes only affect later frames.
            if (fifo_pop) begin
                shift_reg        <= fifo_dout;
                parity_reg       <= parity_bit(word_ext, parity_type);
                par_cfg_reg      <= parity_type;
                two_stop_cfg_reg <= two_stop;
                bit_idx_reg      <= '0;
            end else if (state_reg == DATA && bit_end) begin
                shift_reg   <= shift_reg >> 1;
                bit_idx_reg <= (bit_idx_reg == BIT_LAST) ? '0 : bit_idx_reg + 1'b1;
            end

            if (state_reg != STOP) begin
                stop_idx_reg <= 1'b0;
            end else if (bit_end) begin
                stop_idx_reg <= 1'b1;
            end

            case (state_reg)
                START:   serial_reg <= 1'b0;
                DATA:    serial_reg <= shift_reg[0];
                PARITY:  serial_reg <= parity_reg;
                default: serial_reg <= 1'b1;
            endcase
        end
    end

endmodule
